bus_responder: RTL and testbench

Simulation-side memory responder answering the reference CPU's instruction and data bus requests (`ibus_req_t`/`dbus_req_t`). It sits at the far end of the core's `ireq`/`dreq` outputs. It arbitrates the two buses onto one word-addressed memory array and returns data after a fixed programmable latency. It completes the addr_ok/data_ok handshake the core expects.

---
 rtl/bus_responder_pkg.sv | 48 ++++
 rtl/bus_resp_lfsr.sv | 26 ++
 rtl/bus_responder.sv | 125 ++++++++++++
 tb/tb_bus_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared bus types, responder FSM states and the stall-LFSR seed for bus_responder.
// Byte-lane merge helper used for strobed writes.
package bus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_resp_state_t;

  localparam logic [7:0] BUS_RESP_LFSR_SEED = 8'hA5;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strobe);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strobe[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_resp_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to withhold accepts when
// BUS_RESP_STALL_EN is defined.
module bus_resp_lfsr
  import bus_responder_pkg::*;
#(
  parameter logic [7:0] SEED = BUS_RESP_LFSR_SEED
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] out
);

  logic [7:0] lfsr_r;

  // Shift register advancing every cycle, reloaded with the seed in reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign out = lfsr_r;

endmodule

// File: rtl/bus_responder.sv
// Memory responder for the reference CPU ibus/dbus: dbus-priority arbitration, one
// outstanding transaction, data_ok after LATENCY cycles. Optional: BUS_RESP_STALL_EN.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int    MEM_WORDS = 65536,
  parameter int    LATENCY   = 2,
  parameter string MEM_INIT  = ""
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [31:0]     mem_r [MEM_WORDS];
  bus_resp_state_t state_r;
  bus_resp_state_t state_s;
  logic [3:0]      cnt_r;
  logic            grant_d_r;
  logic [31:0]     rdata_r;
  logic            stall_s;
  logic            accept_s;
  logic [IDX_W-1:0] idx_s;
  logic            unused_s;

`ifdef BUS_RESP_STALL_EN
  logic [7:0] lfsr_s;

  bus_resp_lfsr #(.SEED(BUS_RESP_LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .out    (lfsr_s)
  );

  assign stall_s  = lfsr_s[0];
  assign unused_s = ^{ireq.addr[31:IDX_W+2], ireq.addr[1:0], dreq.addr[31:IDX_W+2],
                      dreq.addr[1:0], dreq.size, lfsr_s[7:1]};
`else
  assign stall_s  = 1'b0;
  assign unused_s = ^{ireq.addr[31:IDX_W+2], ireq.addr[1:0], dreq.addr[31:IDX_W+2],
                      dreq.addr[1:0], dreq.size};
`endif

  // Gated by resetn so nothing is accepted or written while reset is held.
  assign accept_s = resetn && (state_r == IDLE) && !stall_s && (dreq.valid || ireq.valid);
  assign idx_s    = dreq.valid ? dreq.addr[IDX_W+1:2] : ireq.addr[IDX_W+1:2];

  // Control state: FSM, latency counter, grant and captured read word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      grant_d_r <= 1'b1;
      rdata_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r     <= CNT_LOAD;
        grant_d_r <= dreq.valid;
        rdata_r   <= mem_r[idx_s];
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Strobed write at the accept edge; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (accept_s && dreq.valid && (dreq.strobe != 4'd0)) begin
      mem_r[idx_s] <= merge_lanes(mem_r[idx_s], dreq.data, dreq.strobe);
    end
  end

  // Next-state logic; WAIT leaves as the counter steps down to zero.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (LATENCY == 32'sd1) ? RESP : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Response outputs: addr_ok follows the accept decision, data only with data_ok.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    dresp.addr_ok = accept_s && dreq.valid;
    iresp.addr_ok = accept_s && !dreq.valid;
    if (resetn && (state_r == RESP)) begin
      if (grant_d_r) begin
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_r;
      end else begin
        iresp.data_ok = 1'b1;
        iresp.data    = rdata_r;
      end
    end else begin
      iresp.data_ok = 1'b0;
      dresp.data_ok = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: transaction-level model checked every cycle,
// plus directed literal expectations. Build with BUS_RESP_STALL_EN for the stall variant.
module tb_bus_responder;
  import bus_responder_pkg::*;

  localparam int LAT = 2;
  localparam int MW  = 65536;
`ifdef BUS_RESP_STALL_EN
  localparam int NR = 500;
`else
  localparam int NR = 100;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bus_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .MEM_INIT("")) dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: word memory, one pending response, and the stall LFSR sequence.
  logic [31:0] m_mem [int];
  bit          m_busy = 0;
  int          m_resp_cyc = 0;
  bit          m_is_d = 0;
  logic [31:0] m_word = 32'd0;
  logic [7:0]  m_lfsr = 8'hA5;
  int          withheld = 0;

  always @(posedge clk) m_lfsr <= resetn ? {m_lfsr[6:0], ^(m_lfsr & 8'hB8)} : 8'hA5;

  logic        e_iok, e_dok, e_idok, e_ddok, stall;
  logic [31:0] e_idata, e_ddata, tmp, a;
  int          idx;

  always @(negedge clk) begin
    cyc++;
    {e_iok, e_dok, e_idok, e_ddok} = 4'd0;
    e_idata = 32'd0;
    e_ddata = 32'd0;
`ifdef BUS_RESP_STALL_EN
    stall = m_lfsr[0];
`else
    stall = 1'b0;
`endif
    if (!resetn) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (cyc == m_resp_cyc) begin
        if (m_is_d) begin e_ddok = 1'b1; e_ddata = m_word; end
        else begin e_idok = 1'b1; e_idata = m_word; end
        m_busy = 0;
      end
    end else if (dreq.valid || ireq.valid) begin
      if (stall) begin
        withheld++;
      end else begin
        m_is_d = dreq.valid;
        a      = m_is_d ? dreq.addr : ireq.addr;
        idx    = int'((a >> 2) & 32'(MW - 1));
        m_word = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
        if (m_is_d) e_dok = 1'b1; else e_iok = 1'b1;
        if (m_is_d && dreq.strobe != 4'd0) begin
          tmp = m_word;
          for (int b = 0; b < 4; b++)
            if (dreq.strobe[b]) tmp[8*b +: 8] = dreq.data[8*b +: 8];
          m_mem[idx] = tmp;
        end
        m_resp_cyc = cyc + LAT;
        m_busy     = 1;
      end
    end
    chk("iresp.addr_ok", 32'(iresp.addr_ok), 32'(e_iok));
    chk("dresp.addr_ok", 32'(dresp.addr_ok), 32'(e_dok));
    chk("iresp.data_ok", 32'(iresp.data_ok), 32'(e_idok));
    chk("dresp.data_ok", 32'(dresp.data_ok), 32'(e_ddok));
    chk("iresp.data", iresp.data, e_idata);
    chk("dresp.data", dresp.data, e_ddata);
  end

  // Drivers: called at posedge+1, hold the request until data_ok, return at posedge+1.
  task automatic dbus_txn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                          output logic [31:0] rd, output time acc_t, output time ok_t);
    int n = 0;
    bit done = 0;
    rd = 32'd0; acc_t = 0; ok_t = 0;
    dreq.valid = 1'b1; dreq.addr = addr; dreq.size = 3'd2; dreq.strobe = strb; dreq.data = data;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (dresp.addr_ok) acc_t = $time;
      if (dresp.data_ok) begin done = 1; ok_t = $time; rd = dresp.data; end
    end
    if (!done) chk("dbus_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
  endtask

  task automatic ibus_txn(input logic [31:0] addr, output logic [31:0] rd,
                          output time acc_t, output time ok_t);
    int n = 0;
    bit done = 0;
    rd = 32'd0; acc_t = 0; ok_t = 0;
    ireq.valid = 1'b1; ireq.addr = addr;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (iresp.addr_ok) acc_t = $time;
      if (iresp.data_ok) begin done = 1; ok_t = $time; rd = iresp.data; end
    end
    if (!done) chk("ibus_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ireq.valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    time         t0, t1, t2, t3;
    bit          seen;
    int          n;

    ireq = '0;
    dreq = '0;
    ireq.valid = 1'b1;            // request during reset must not be accepted
    ireq.addr  = 32'h4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {28'd0, iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}, 32'd0);
    chk("reset_idata", iresp.data, 32'd0);
    ireq.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 64; i++)
      dbus_txn(32'(i) << 2, 4'hF, 32'h5A00_0000 + 32'(i) * 32'h0001_0203, rd, t0, t1);

    // Instruction fetch of word 1 after loading it
    dbus_txn(32'h0000_0004, 4'hF, 32'h2402_0001, rd, t0, t1);
    ibus_txn(32'h0000_0004, rd, t0, t1);
    chk("ifetch_data", rd, 32'h2402_0001);
    chk("ifetch_latency", 32'((t1 - t0) / 10), 32'd2);

    // Partial write returns old word; read-back shows merged lanes
    dbus_txn(32'h0000_0010, 4'hF, 32'h1122_3344, rd, t0, t1);
    dbus_txn(32'h0000_0010, 4'b0011, 32'hAABB_CCDD, rd, t0, t1);
    chk("partial_write_old", rd, 32'h1122_3344);
    dbus_txn(32'h0000_0010, 4'h0, 32'h0, rd, t0, t1);
    chk("partial_write_new", rd, 32'h1122_CCDD);

    // Simultaneous requests: dbus first, ibus right after dbus data_ok
    dbus_txn(32'h0000_0008, 4'hF, 32'hCAFE_0002, rd, t0, t1);
    dbus_txn(32'h0000_000C, 4'hF, 32'h0000_BEEF, rd, t0, t1);
    fork
      dbus_txn(32'h0000_0008, 4'h0, 32'h0, rd, t0, t1);
      ibus_txn(32'h0000_000C, rd2, t2, t3);
    join
    chk("simul_dbus_data", rd, 32'hCAFE_0002);
    chk("simul_ibus_data", rd2, 32'h0000_BEEF);
`ifndef BUS_RESP_STALL_EN
    chk("simul_ibus_after_dbus", 32'((t2 - t1) / 10), 32'd1);
`endif

    // Address wrap-around
    dbus_txn(32'h0004_0008, 4'h0, 32'h0, rd, t0, t1);
    chk("alias_word2", rd, 32'hCAFE_0002);

    // Reset one cycle after accept drops the response
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_0004;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = iresp.addr_ok;
    end
    chk("midreset_accept", 32'(seen), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    ireq.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (iresp.data_ok || dresp.data_ok) seen = 1;
    end
    chk("midreset_no_data_ok", 32'(seen), 32'd0);
    @(posedge clk); #1;
    ibus_txn(32'h0000_0004, rd, t0, t1);
    chk("after_reset_fetch", rd, 32'h2402_0001);

    // Random traffic from both masters; the per-cycle model does the checking
    fork
      begin
        logic [31:0] r; time ta, tb;
        for (int k = 0; k < NR; k++) begin
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          dbus_txn(($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), $urandom, r, ta, tb);
        end
      end
      begin
        logic [31:0] r; time ta, tb;
        for (int k = 0; k < NR; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          ibus_txn(($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2), r, ta, tb);
        end
      end
    join
`ifdef BUS_RESP_STALL_EN
    chk("withheld_seen", 32'(withheld > 0), 32'd1);
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
